instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): output buffer entries.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse: load base_addr, enter RUN.
REQ-005 SHALL have port base_addr  input  16  first instruction-memory address.
REQ-006 SHALL have port in_valid  input  1  request carries a decoded instruction.
REQ-007 SHALL have port in_ready  output  1  encoder accepts request this cycle.
REQ-008 SHALL have port in_op  input  4  opcode: 0-7 ALU, 8 LW, 9 SW, A LHB, B LLB, C B, D CALL, E RET, F HALT.
REQ-009 SHALL have port in_a, in_b, in_c  input  4 each  register/condition fields.
REQ-010 SHALL have port in_imm  input  12  immediate/offset.
REQ-011 SHALL have port out_valid  output  1  buffer head valid.
REQ-012 SHALL have port out_ready  input  1  instruction-memory writer consumes head.
REQ-013 SHALL have port out_instr  output  16  encoded word at head.
REQ-014 SHALL have port out_addr  output  16  target address of head word.
REQ-015 SHALL have port busy  output  1  state is RUN.
REQ-016 SHALL have port halted  output  1  state is HALTED.
REQ-017 SHALL have port err  output  1  sticky: illegal request seen.

Function
REQ-018 Encoding SHALL be: ALU {op,a,b,c}; LW/SW {op,a,b,imm[3:0]}; LHB/LLB {op,a,imm[7:0]}; B {op,a[2:0],imm[8:0]}; CALL {op,imm[11:0]}; RET {op,12'h000}; HALT 16'hFFFF regardless of fields.
REQ-019 FSM states SHALL be IDLE, RUN, HALTED; IDLE->RUN on start; RUN->HALTED when HALT accepted; HALTED->RUN on start; start in RUN reloads address counter only.
REQ-020 in_ready SHALL equal (state==RUN) && buffer not full; no combinational path from out_ready.
REQ-021 Accept (in_valid && in_ready) at edge N SHALL make the word visible in buffer at edge N, out_valid at latest in cycle N+1 if buffer was empty.
REQ-022 Each accepted word SHALL take address counter value, then counter increments by 1, wrapping FFFF->0000.
REQ-023 Buffer SHALL be FIFO order; pop on out_valid && out_ready; simultaneous push and pop when full SHALL NOT push (in_ready already 0).
REQ-024 out_instr/out_addr SHALL be stable while out_valid && !out_ready.
REQ-025 In HALTED the buffer SHALL continue draining; no new accepts.
REQ-026 start coincident with accept SHALL apply start first: accepted word takes base_addr.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, empty buffer, address counter 0, err 0.
REQ-028 Output reset values SHALL be in_ready 0, out_valid 0, out_instr 0, out_addr 0, busy 0, halted 0, err 0; reset mid-stream discards buffered words.

Configuration
REQ-029 With INSTR_ENC_RANGECHK_EN defined, a request whose in_imm has nonzero bits outside its opcode field width (LW/SW >[3:0], LHB/LLB >[7:0], B >[8:0], RET any) SHALL be accepted, not buffered, not counted, and set err.
REQ-030 Without INSTR_ENC_RANGECHK_EN, excess in_imm bits SHALL be silently truncated per REQ-018 and err SHALL remain 0.

Verification
REQ-031 Reset, start base 0x0100, ADD a=1 b=2 c=3 -> out_instr 0x0123, out_addr 0x0100.
REQ-032 LLB a=5 imm=0x3C then B a=2 imm=0x1F0 -> 0xB53C at 0x0100, 0xC5F0 at 0x0101.
REQ-033 out_ready held 0, push FIFO_DEPTH words -> in_ready 0 after 4th; release -> 4 words drain in order, no loss.
REQ-034 base 0xFFFF, two words -> out_addr 0xFFFF then 0x0000.
REQ-035 HALT with nonzero fields -> 0xFFFF emitted, halted 1, in_ready 0; start -> busy 1.
REQ-036 With INSTR_ENC_RANGECHK_EN, LW imm=0x010 -> no output, err 1; without -> 0x8xx0 emitted, err 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded requests into 16-bit words, tags them with a running
// address and buffers them in a FIFO. Optional immediate range check: INSTR_ENC_RANGECHK_EN.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic [3:0]  in_c,
    input  logic [11:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_addr,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;

    logic [15:0] buf_instr_q [FIFO_DEPTH];
    logic [15:0] buf_addr_q  [FIFO_DEPTH];

    logic [15:0] enc_word;
    logic [15:0] word_addr;
    logic        imm_legal;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    assign wr_idx     = wr_ptr_q[PW-1:0];
    assign rd_idx     = rd_ptr_q[PW-1:0];
    // Extra pointer MSB tells full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);

    assign in_ready  = (state_q == ST_RUN) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && imm_legal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign word_addr = start ? base_addr : addr_q;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        enc_word = 16'h0000;
        case (in_op)
            4'h8, 4'h9: enc_word = {in_op, in_a, in_b, in_imm[3:0]};
            4'hA, 4'hB: enc_word = {in_op, in_a, in_imm[7:0]};
            4'hC:       enc_word = {in_op, in_a[2:0], in_imm[8:0]};
            4'hD:       enc_word = {in_op, in_imm};
            4'hE:       enc_word = {in_op, 12'h000};
            4'hF:       enc_word = 16'hFFFF;
            default:    enc_word = {in_op, in_a, in_b, in_c};
        endcase
    end

`ifdef INSTR_ENC_RANGECHK_EN
    always_comb begin
        imm_legal = 1'b1;
        case (in_op)
            4'h8, 4'h9: imm_legal = (in_imm[11:4] == 8'h00);
            4'hA, 4'hB: imm_legal = (in_imm[11:8] == 4'h0);
            4'hC:       imm_legal = (in_imm[11:9] == 3'h0);
            4'hE:       imm_legal = (in_imm == 12'h000);
            default:    imm_legal = 1'b1;
        endcase
    end
`else
    assign imm_legal = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        err_d    = err_q | (accept & ~imm_legal);
        wr_ptr_d = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;

        // Start is applied before the accept, so a coincident word takes base_addr.
        if (start) begin
            addr_d = base_addr;
        end
        if (push) begin
            addr_d = word_addr + 16'd1;
        end

        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (push && in_op == 4'hF) state_d = ST_HALTED;
            ST_HALTED: if (start) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 16'h0000;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: buffer storage has no reset; pointers define validity and outputs are gated while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_idx] <= enc_word;
            buf_addr_q[wr_idx]  <= word_addr;
        end
    end

    assign out_instr = out_valid ? buf_instr_q[rd_idx] : 16'h0000;
    assign out_addr  = out_valid ? buf_addr_q[rd_idx]  : 16'h0000;
    assign busy      = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALTED);
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// scored against a queue-based reference model of the encoder.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'h0;
    logic [3:0]  in_a = 4'h0;
    logic [3:0]  in_b = 4'h0;
    logic [3:0]  in_c = 4'h0;
    logic [11:0] in_imm = 12'h000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_addr;
    logic        busy;
    logic        halted;
    logic        err;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 run, 2 halted; queue entries are {addr, instr}.
    int          m_state = 0;
    logic [15:0] m_addr = 16'h0000;
    logic        m_err = 1'b0;
    logic [31:0] m_q[$];

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
        .in_b(in_b), .in_c(in_c), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_encode(int op, int a, int b, int c, int imm);
        int w;
        if (op <= 7)                  w = op * 4096 + a * 256 + b * 16 + c;
        else if (op == 8 || op == 9)  w = op * 4096 + a * 256 + b * 16 + (imm % 16);
        else if (op == 10 || op == 11) w = op * 4096 + a * 256 + (imm % 256);
        else if (op == 12)            w = op * 4096 + (a % 8) * 512 + (imm % 512);
        else if (op == 13)            w = op * 4096 + imm;
        else if (op == 14)            w = 14 * 4096;
        else                          w = 65535;
        return w[15:0];
    endfunction

    function automatic bit ref_legal(int op, int imm);
`ifdef INSTR_ENC_RANGECHK_EN
        if (op == 8 || op == 9)   return imm < 16;
        if (op == 10 || op == 11) return imm < 256;
        if (op == 12)             return imm < 512;
        if (op == 14)             return imm == 0;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_addr  = 16'h0000;
        m_err   = 1'b0;
        m_q.delete();
    endtask

    task automatic req(input int op, input int a, input int b, input int c, input int imm);
        in_valid = 1'b1;
        in_op    = op[3:0];
        in_a     = a[3:0];
        in_b     = b[3:0];
        in_c     = c[3:0];
        in_imm   = imm[11:0];
    endtask

    // One clock: score current outputs, advance the model, cross the edge, score state.
    task automatic step();
        bit          exp_ready, acc, pop;
        logic [15:0] wa;
        logic [31:0] head;
        exp_ready = (m_state == 1) && (m_q.size() < DEPTH);
        checks++;
        if (in_ready !== exp_ready) begin
            failures++;
            $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, exp_ready, $time);
        end
        checks++;
        if (out_valid !== (m_q.size() != 0)) begin
            failures++;
            $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, m_q.size() != 0, $time);
        end
        if (m_q.size() != 0) begin
            head = m_q[0];
            checks++;
            if (out_instr !== head[15:0] || out_addr !== head[31:16]) begin
                failures++;
                $display("FAIL head got=%h@%h exp=%h@%h t=%0t", out_instr, out_addr,
                         head[15:0], head[31:16], $time);
            end
        end
        acc = in_valid && exp_ready;
        pop = (m_q.size() != 0) && out_ready;
        wa  = start ? base_addr : m_addr;
        if (start) begin
            m_addr = base_addr;
            if (m_state != 1) m_state = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (ref_legal(in_op, in_imm)) begin
                m_q.push_back({wa, ref_encode(in_op, in_a, in_b, in_c, in_imm)});
                m_addr = wa + 16'd1;
                if (in_op == 4'hF) m_state = 2;
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== m_err || busy !== (m_state == 1) || halted !== (m_state == 2)) begin
            failures++;
            $display("FAIL status got=err%b busy%b halt%b exp=err%b busy%b halt%b t=%0t",
                     err, busy, halted, m_err, m_state == 1, m_state == 2, $time);
        end
    endtask

    task automatic drain();
        int budget;
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (m_q.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        checks++;
        if (m_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d left exp=0", m_q.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, out_valid, out_instr, out_addr, busy, halted, err} !== 37'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b %h %h %b%b%b exp=all zero",
                     in_ready, out_valid, out_instr, out_addr, busy, halted, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step();
    endtask

    task automatic test_basic();
        start = 1'b1; base_addr = 16'h0100;
        step();
        start = 1'b0;
        req(0, 1, 2, 3, 0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'h0123 || out_addr !== 16'h0100) begin
            failures++;
            $display("FAIL add_word got=%b %h@%h exp=1 0123@0100", out_valid, out_instr, out_addr);
        end
        drain();
        // Start coincident with the LLB accept: the word must take the new base.
        start = 1'b1; base_addr = 16'h0100;
        req(11, 5, 0, 0, 12'h03C);
        step();
        start = 1'b0;
        req(12, 2, 0, 0, 12'h1F0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_instr !== 16'hB53C || out_addr !== 16'h0100) begin
            failures++;
            $display("FAIL llb_word got=%h@%h exp=B53C@0100", out_instr, out_addr);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_instr !== 16'hC5F0 || out_addr !== 16'h0101) begin
            failures++;
            $display("FAIL branch_word got=%h@%h exp=C5F0@0101", out_instr, out_addr);
        end
        drain();
    endtask

    task automatic test_full();
        start = 1'b1; base_addr = 16'h0200; out_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            req($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), 0);
            step();
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_in_ready got=%b exp=0", in_ready);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_addr !== 16'h0200 + 16'(i)) begin
                failures++;
                $display("FAIL full_order got=%h exp=%h", out_addr, 16'h0200 + 16'(i));
            end
            step();
        end
        drain();
    endtask

    task automatic test_wrap();
        start = 1'b1; base_addr = 16'hFFFF;
        req(3, 1, 1, 1, 0);
        step();
        start = 1'b0;
        req(4, 2, 2, 2, 0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_addr !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_first got=%h exp=FFFF", out_addr);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_addr !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_second got=%h exp=0000", out_addr);
        end
        drain();
    endtask

    task automatic test_halt();
        req(15, 3, 4, 5, 12'hABC);
        step();
        req(1, 1, 1, 1, 0);
        checks++;
        if (halted !== 1'b1 || in_ready !== 1'b0 || out_instr !== 16'hFFFF) begin
            failures++;
            $display("FAIL halt got=halt%b rdy%b %h exp=halt1 rdy0 FFFF", halted, in_ready, out_instr);
        end
        step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        start = 1'b1; base_addr = 16'h0400;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL restart got=busy%b halt%b exp=busy1 halt0", busy, halted);
        end
        drain();
    endtask

    task automatic test_imm_range();
        start = 1'b1; base_addr = 16'h0300;
        step();
        start = 1'b0;
        req(8, 1, 2, 0, 12'h010);
        step();
        in_valid = 1'b0;
`ifdef INSTR_ENC_RANGECHK_EN
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL lw_range got=valid%b err%b exp=valid0 err1", out_valid, err);
        end
`else
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 16'h8120 || err !== 1'b0) begin
            failures++;
            $display("FAIL lw_trunc got=%b %h err%b exp=1 8120 err0", out_valid, out_instr, err);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 15);
            if (op == 15 && $urandom_range(0, 3) != 0) op = 13;
            start     = ($urandom_range(0, 15) == 0) || (m_state != 1 && $urandom_range(0, 3) == 0);
            base_addr = 16'($urandom);
            in_valid  = $urandom_range(0, 3) != 0;
            in_op     = op[3:0];
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_c      = 4'($urandom);
            in_imm    = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        start = 1'b1; base_addr = 16'h0500; out_ready = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(2, i, i, i, 0);
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_instr, out_addr, busy, halted, err} !== 37'h0) begin
            failures++;
            $display("FAIL async_reset got=%b%b %h %h %b%b%b exp=all zero",
                     in_ready, out_valid, out_instr, out_addr, busy, halted, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step();
        start = 1'b1; base_addr = 16'h0600;
        step();
        start = 1'b0;
        req(7, 7, 7, 7, 0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_instr !== 16'h7777 || out_addr !== 16'h0600) begin
            failures++;
            $display("FAIL post_reset got=%h@%h exp=7777@0600", out_instr, out_addr);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_halt();
        test_random();
        test_imm_range();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
